serial_addsub_digit: RTL and testbench

Digit-serial two's-complement adder/subtractor that processes one DIGIT_W-bit digit per cycle, least-significant digit first, over words of WORD_DIGITS digits. It is the parametrised successor of the 1-bit serial adder in the sequential-basics set. It adds word framing, a per-word add/subtract mode, valid-qualified stalling and end-of-word carry/overflow flags. It sits between a digit-serial source (e.g. a shift-register unloader) and a digit-serial sink.

---
 rtl/serial_addsub_digit.sv | 94 +++++++++
 tb/tb_serial_addsub_digit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_digit.sv
// Digit-serial two's-complement adder/subtractor, LSD first, with word framing,
// per-word add/sub mode, in_valid stalling and end-of-word carry/overflow flags.

module serial_addsub_digit_fa (
  input  logic i_x,
  input  logic i_y,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y ^ i_c;
  assign o_c = (i_x & i_y) | (i_c & (i_x ^ i_y));
endmodule

module serial_addsub_digit #(
  parameter int DIGIT_W     = 1,
  parameter int WORD_DIGITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               sub,
  output logic               out_valid,
  output logic [DIGIT_W-1:0] sum,
  output logic               last,
  output logic               carry_out,
  output logic               overflow
);
  localparam int CNT_W = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_DIGITS - 1);

  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_mode;

  logic               w_first;
  logic               w_last;
  logic               w_inv;
  logic [DIGIT_W-1:0] w_b;
  logic [DIGIT_W-1:0] w_s;
  logic [DIGIT_W:0]   w_c;

  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == LAST_CNT);

  // The first digit takes its mode straight from sub; later digits use the latch.
  assign w_inv   = w_first ? sub : r_mode;
  assign w_b     = b ^ {DIGIT_W{w_inv}};
  assign w_c[0]  = w_first ? sub : r_carry;

  generate
    for (genvar i = 0; i < DIGIT_W; i++) begin : g_cell
      serial_addsub_digit_fa u_fa (
        .i_x (a[i]),
        .i_y (w_b[i]),
        .i_c (w_c[i]),
        .o_s (w_s[i]),
        .o_c (w_c[i+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_mode    <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      last      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum       <= w_s;
        last      <= w_last;
        carry_out <= w_last & w_c[DIGIT_W];
        overflow  <= w_last & (w_c[DIGIT_W-1] ^ w_c[DIGIT_W]);
        r_carry   <= w_c[DIGIT_W];
        r_mode    <= w_inv;
        r_cnt     <= w_last ? '0 : r_cnt + CNT_W'(1);
      end else begin
        // Gaps present all-zero outputs so the sink never sees stale data.
        sum       <= '0;
        last      <= 1'b0;
        carry_out <= 1'b0;
        overflow  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_addsub_digit.sv
// Bench for serial_addsub_digit: three configurations checked every cycle
// against a whole-word arithmetic model delayed by one cycle.

module tb_serial_addsub_digit;
  localparam int NI = 3;
  localparam int DWS [NI] = '{1, 4, 8};
  localparam int WDS [NI] = '{8, 2, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v_d [NI];
  logic [15:0] a_d [NI];
  logic [15:0] b_d [NI];
  logic        s_d [NI];

  // next-cycle expectations set by the stimulus, and their registered copy
  logic        nv [NI], nl [NI], nc [NI], no [NI];
  logic [15:0] ns [NI];
  logic        ev [NI], el [NI], ec [NI], eo [NI];
  logic [15:0] es [NI];

  logic        g_v [NI], g_l [NI], g_c [NI], g_o [NI];
  logic [15:0] g_s [NI];
  logic [0:0]  sm0;
  logic [3:0]  sm1;
  logic [7:0]  sm2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  serial_addsub_digit #(.DIGIT_W(1), .WORD_DIGITS(8)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(v_d[0]), .a(a_d[0][0:0]), .b(b_d[0][0:0]),
    .sub(s_d[0]), .out_valid(g_v[0]), .sum(sm0), .last(g_l[0]),
    .carry_out(g_c[0]), .overflow(g_o[0]));

  serial_addsub_digit #(.DIGIT_W(4), .WORD_DIGITS(2)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(v_d[1]), .a(a_d[1][3:0]), .b(b_d[1][3:0]),
    .sub(s_d[1]), .out_valid(g_v[1]), .sum(sm1), .last(g_l[1]),
    .carry_out(g_c[1]), .overflow(g_o[1]));

  serial_addsub_digit #(.DIGIT_W(8), .WORD_DIGITS(1)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(v_d[2]), .a(a_d[2][7:0]), .b(b_d[2][7:0]),
    .sub(s_d[2]), .out_valid(g_v[2]), .sum(sm2), .last(g_l[2]),
    .carry_out(g_c[2]), .overflow(g_o[2]));

  assign g_s[0] = 16'(sm0);
  assign g_s[1] = 16'(sm1);
  assign g_s[2] = 16'(sm2);

  initial begin
    for (int k = 0; k < NI; k++) begin
      ev[k] = 0; el[k] = 0; ec[k] = 0; eo[k] = 0; es[k] = '0;
    end
  end

  // One-cycle output latency; reset wins over a simultaneous digit.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      ev[k] <= rst ? 1'b0 : nv[k];
      es[k] <= rst ? 16'h0 : ns[k];
      el[k] <= rst ? 1'b0 : nl[k];
      ec[k] <= rst ? 1'b0 : nc[k];
      eo[k] <= rst ? 1'b0 : no[k];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        checks++;
        if ({g_v[k], g_s[k], g_l[k], g_c[k], g_o[k]} !== {ev[k], es[k], el[k], ec[k], eo[k]}) begin
          errors++;
          $display("FAIL out_inst%0d t=%0t got v=%b sum=%h last=%b co=%b ov=%b, want v=%b sum=%h last=%b co=%b ov=%b",
                   k, $time, g_v[k], g_s[k], g_l[k], g_c[k], g_o[k],
                   ev[k], es[k], el[k], ec[k], eo[k]);
        end
      end
    end
  end

  // Whole-word reference: A + (sub ? ~B : B) + sub over DIGIT_W*WORD_DIGITS bits.
  function automatic void model(input int k, input logic [63:0] A, input logic [63:0] B,
                                input bit s, output logic [63:0] res, output bit co, output bit ov);
    int w;
    logic [63:0] m, am, bp, full;
    w    = DWS[k] * WDS[k];
    m    = (64'd1 << w) - 64'd1;
    am   = A & m;
    bp   = (s ? ~B : B) & m;
    full = am + bp + 64'(s);
    res  = full & m;
    co   = full[w];
    ov   = (am[w-1] == bp[w-1]) && (res[w-1] != am[w-1]);
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    for (int k = 0; k < NI; k++) begin
      v_d[k] = 1'b0;
      a_d[k] = 16'($urandom);
      b_d[k] = 16'($urandom);
      s_d[k] = 1'($urandom);
      nv[k] = 0; nl[k] = 0; nc[k] = 0; no[k] = 0; ns[k] = '0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      set_idle();
      step();
    end
  endtask

  // Drives ndig digits of a word on instance k; stall_mask bit d inserts 3 idle cycles after digit d.
  task automatic word(input int k, input logic [63:0] A, input logic [63:0] B, input bit s,
                      input bit tog, input int stall_mask, input int ndig);
    logic [63:0] res, dm;
    bit co, ov;
    int dw, wd;
    dw = DWS[k];
    wd = WDS[k];
    dm = (64'd1 << dw) - 64'd1;
    model(k, A, B, s, res, co, ov);
    for (int d = 0; d < ndig; d++) begin
      set_idle();
      v_d[k] = 1'b1;
      a_d[k] = 16'((A >> (d * dw)) & dm);
      b_d[k] = 16'((B >> (d * dw)) & dm);
      s_d[k] = (d == 0 || !tog) ? s : 1'($urandom);
      nv[k]  = 1'b1;
      ns[k]  = 16'((res >> (d * dw)) & dm);
      nl[k]  = (d == wd - 1);
      nc[k]  = (d == wd - 1) & co;
      no[k]  = (d == wd - 1) & ov;
      step();
      if (stall_mask[d]) idle(3);
    end
  endtask

  task automatic reset_cycle(input int k);
    set_idle();
    v_d[k] = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] r;
    bit co, ov;

    // Pin the model with hand-computed results.
    model(0, 64'h5A, 64'h33, 1'b0, r, co, ov);
    chk("model_5A+33_sum", r, 64'h8D); chk("model_5A+33_co", 64'(co), 0); chk("model_5A+33_ov", 64'(ov), 1);
    model(0, 64'h10, 64'h20, 1'b1, r, co, ov);
    chk("model_10-20_sum", r, 64'hF0); chk("model_10-20_co", 64'(co), 0); chk("model_10-20_ov", 64'(ov), 0);
    model(1, 64'h80, 64'h01, 1'b1, r, co, ov);
    chk("model_80-01_sum", r, 64'h7F); chk("model_80-01_co", 64'(co), 1); chk("model_80-01_ov", 64'(ov), 1);
    model(2, 64'h00, 64'h01, 1'b1, r, co, ov);
    chk("model_00-01_sum", r, 64'hFF); chk("model_00-01_co", 64'(co), 0); chk("model_00-01_ov", 64'(ov), 0);

    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    idle(2);

    // directed cases
    word(0, 64'h5A, 64'h33, 1'b0, 1'b0, 0, 8);
    word(0, 64'h10, 64'h20, 1'b1, 1'b1, 0, 8);
    word(0, 64'h5A, 64'h33, 1'b0, 1'b0, 'b10010, 8);
    idle(1);
    word(0, 64'h37, 64'h4C, 1'b1, 1'b0, 0, 4);
    reset_cycle(0);
    idle(2);
    word(0, 64'h01, 64'h01, 1'b0, 1'b0, 0, 8);
    word(1, 64'hFF, 64'h01, 1'b0, 1'b0, 0, 2);
    word(1, 64'h80, 64'h01, 1'b1, 1'b0, 0, 2);
    word(2, 64'h7F, 64'h01, 1'b0, 1'b0, 0, 1);
    word(2, 64'h00, 64'h01, 1'b1, 1'b0, 0, 1);
    idle(2);

    // randomized words, stalls, sub toggling and occasional aborted words
    for (int it = 0; it < 120; it++) begin
      int k;
      k = $urandom_range(0, NI - 1);
      if ($urandom_range(0, 11) == 0 && WDS[k] > 1) begin
        word(k, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b1, 0,
             $urandom_range(1, WDS[k] - 1));
        reset_cycle(k);
      end else begin
        word(k, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom) : 0, WDS[k]);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(3);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
